// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - device-side 4x4 matrix keypad model driven by press requests
// Presses one latched key for HOLD_CYCLES, then releases it for GAP_CYCLES.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       cancel,
    input  logic [3:0] row,
    output logic [3:0] column,
    output logic       busy,
    output logic       pressing,
    output logic       done
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_key;
    logic [3:0]    w_key_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic [3:0]    w_row_s;
    logic [1:0]    w_key_row;
    logic [1:0]    w_key_col;
    logic          w_drive;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_row_s = row;
        end else begin : g_sync
            logic [3:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= 4'b1111;
                    end
                end else begin
                    r_sync[0] <= row;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_row_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Code map matches the scanner: {row index, column index} per key code.
    always_comb begin
        w_key_row = 2'd0;
        w_key_col = 2'd0;
        case (r_key)
            4'h1: begin w_key_row = 2'd0; w_key_col = 2'd0; end
            4'h2: begin w_key_row = 2'd0; w_key_col = 2'd1; end
            4'h3: begin w_key_row = 2'd0; w_key_col = 2'd2; end
            4'hA: begin w_key_row = 2'd0; w_key_col = 2'd3; end
            4'h4: begin w_key_row = 2'd1; w_key_col = 2'd0; end
            4'h5: begin w_key_row = 2'd1; w_key_col = 2'd1; end
            4'h6: begin w_key_row = 2'd1; w_key_col = 2'd2; end
            4'hB: begin w_key_row = 2'd1; w_key_col = 2'd3; end
            4'h7: begin w_key_row = 2'd2; w_key_col = 2'd0; end
            4'h8: begin w_key_row = 2'd2; w_key_col = 2'd1; end
            4'h9: begin w_key_row = 2'd2; w_key_col = 2'd2; end
            4'hC: begin w_key_row = 2'd2; w_key_col = 2'd3; end
            4'hE: begin w_key_row = 2'd3; w_key_col = 2'd0; end
            4'h0: begin w_key_row = 2'd3; w_key_col = 2'd1; end
            4'hF: begin w_key_row = 2'd3; w_key_col = 2'd2; end
            4'hD: begin w_key_row = 2'd3; w_key_col = 2'd3; end
            default: begin w_key_row = 2'd0; w_key_col = 2'd0; end
        endcase
    end

    // Exact pattern match rejects idle, all-low and multi-row drives in one compare.
    assign w_drive = (r_state == S_PRESS) && (w_row_s == ~(4'b0001 << w_key_row));
    assign column  = w_drive ? ~(4'b0001 << w_key_col) : 4'b1111;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_key_nxt   = r_key;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_valid) begin
                    w_key_nxt   = key_in;
                    w_cnt_nxt   = CW'(HOLD_CYCLES);
                    w_state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (cancel || (r_cnt <= CW'(1))) begin
                    w_cnt_nxt   = CW'(GAP_CYCLES);
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt <= CW'(1)) begin
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= 4'h0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_key   <= w_key_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign key_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign pressing  = (r_state == S_PRESS);
    assign done      = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - directed self-checking bench for keypad_emulator
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic       cancel;
    logic [3:0] row;
    logic [3:0] column;
    logic       busy;
    logic       pressing;
    logic       done;

    logic [3:0] key2;
    logic       kv2;
    logic       key_ready2;
    logic [3:0] row2;
    logic [3:0] column2;
    logic       busy2;
    logic       pressing2;
    logic       done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    keypad_emulator #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .cancel(cancel), .row(row), .column(column),
        .busy(busy), .pressing(pressing), .done(done)
    );

    // Long hold so a full row scan fits inside one press.
    keypad_emulator #(.HOLD_CYCLES(48), .GAP_CYCLES(3), .SYNC_STAGES(2)) u_dut_scan (
        .clk(clk), .rst_n(rst_n), .key_in(key2), .key_valid(kv2),
        .key_ready(key_ready2), .cancel(1'b0), .row(row2), .column(column2),
        .busy(busy2), .pressing(pressing2), .done(done2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] seq [5];
        logic [3:0] prev;
        logic [3:0] exp_col;

        rst_n = 1'b0; key_in = 4'h0; key_valid = 1'b0; cancel = 1'b0; row = 4'b1111;
        key2 = 4'h0; kv2 = 1'b0; row2 = 4'b1111;
        #2;
        chk("rst_column", column, 4'b1111);
        chk("rst_ready", key_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pressing", pressing, 1'b0);
        chk("rst_done", done, 1'b0);
        #10;
        rst_n = 1'b1;
        cyc();

        // Key 5 (row[1], c1): full press/gap/done timeline.
        row = 4'b1101;
        cyc(); cyc();
        key_in = 4'h5; key_valid = 1'b1;
        cyc();
        chk("k5_press1_pressing", pressing, 1'b1);
        chk("k5_press1_ready", key_ready, 1'b0);
        chk("k5_press1_column", column, 4'b1101);
        key_valid = 1'b0; key_in = 4'h3;
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk("k5_press_column", column, 4'b1101);
            chk("k5_press_pressing", pressing, 1'b1);
        end
        cyc();
        chk("k5_gap1_pressing", pressing, 1'b0);
        chk("k5_gap1_busy", busy, 1'b1);
        chk("k5_gap1_column", column, 4'b1111);
        cyc();
        chk("k5_gap2_busy", busy, 1'b1);
        cyc();
        chk("k5_gap3_busy", busy, 1'b1);
        chk("k5_gap3_done", done, 1'b0);
        cyc();
        chk("k5_done", done, 1'b1);
        chk("k5_done_ready", key_ready, 1'b1);
        chk("k5_done_busy", busy, 1'b0);
        cyc();
        chk("k5_done_pulse_end", done, 1'b0);

        // Key 0 (row[3], c1) with invalid row patterns: column never drives.
        row = 4'b0011;
        cyc(); cyc();
        key_in = 4'h0; key_valid = 1'b1;
        cyc();
        chk("k0_pressing", pressing, 1'b1);
        chk("k0_row0011", column, 4'b1111);
        key_valid = 1'b0; row = 4'b1111;
        cyc();
        chk("k0_row0011_b", column, 4'b1111);
        row = 4'b0000;
        cyc();
        chk("k0_row1111", column, 4'b1111);
        cyc();
        chk("k0_row0000", column, 4'b1111);
        chk("k0_still_pressing", pressing, 1'b1);
        cyc(); cyc(); cyc(); cyc();
        chk("k0_done", done, 1'b1);
        cyc();

        // Key A (row[0], c3) cancelled on its second press cycle.
        row = 4'b1110;
        cyc(); cyc();
        key_in = 4'hA; key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        chk("kA_press1_column", column, 4'b0111);
        cyc();
        chk("kA_press2_pressing", pressing, 1'b1);
        chk("kA_press2_column", column, 4'b0111);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        chk("kA_cancel_pressing", pressing, 1'b0);
        chk("kA_cancel_busy", busy, 1'b1);
        chk("kA_cancel_column", column, 4'b1111);
        cyc();
        chk("kA_gap2_busy", busy, 1'b1);
        cyc();
        chk("kA_gap3_busy", busy, 1'b1);
        chk("kA_gap3_done", done, 1'b0);
        cyc();
        chk("kA_done", done, 1'b1);
        chk("kA_done_ready", key_ready, 1'b1);
        cyc();

        // Back-to-back keys 1 then 2 with key_valid held; cancel in IDLE is ignored.
        key_in = 4'h1; key_valid = 1'b1; cancel = 1'b1;
        cyc();
        cancel = 1'b0; key_in = 4'h2;
        chk("b2b_k1_pressing", pressing, 1'b1);
        chk("b2b_k1_column", column, 4'b1110);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk("b2b_k1_press_ready", key_ready, 1'b0);
            chk("b2b_k1_press_column", column, 4'b1110);
        end
        cyc();
        chk("b2b_k1_gap_pressing", pressing, 1'b0);
        cyc(); cyc();
        chk("b2b_k1_gap_ready", key_ready, 1'b0);
        cyc();
        chk("b2b_k1_done", done, 1'b1);
        chk("b2b_k1_done_ready", key_ready, 1'b1);
        cyc();
        chk("b2b_k2_pressing", pressing, 1'b1);
        chk("b2b_k2_done_cleared", done, 1'b0);
        chk("b2b_k2_column", column, 4'b1101);
        key_valid = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        chk("b2b_k2_done", done, 1'b1);
        cyc();

        // Key E (row[3], c0) on the long-hold instance while the rows are scanned.
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;
        row2 = 4'b1110; key2 = 4'hE; kv2 = 1'b1;
        chk("scan_ready", key_ready2, 1'b1);
        cyc();
        kv2 = 1'b0;
        chk("scan_pressing", pressing2, 1'b1);
        prev = 4'b1110;
        for (int r = 0; r < 5; r++) begin
            row2 = seq[r];
            for (int j = 0; j < 8; j++) begin
                if ((seq[r] == 4'b0111 && j >= 2) || (prev == 4'b0111 && j < 2))
                    exp_col = 4'b1110;
                else
                    exp_col = 4'b1111;
                chk("scan_column", column2, exp_col);
                cyc();
            end
            prev = seq[r];
        end
        chk("scan_busy", busy2, 1'b1);
        chk("scan_no_done", done2, 1'b0);

        // Key 9 (row[2], c2) interrupted by asynchronous reset.
        row = 4'b1011;
        cyc(); cyc();
        key_in = 4'h9; key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        chk("k9_column", column, 4'b1011);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("k9_rst_column", column, 4'b1111);
        chk("k9_rst_pressing", pressing, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("k9_post_ready", key_ready, 1'b1);
        chk("k9_post_busy", busy, 1'b0);
        cyc();
        chk("k9_post_column", column, 4'b1111);
        chk("k9_post_idle", key_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
